// File: rtl/req_encoder_4to2.sv
// Collects one-bit request strobes into a pending mask and encodes them one at a time
// as a 2-bit index with a valid/ready handshake. Optional sticky overrun flag: REQ_ENC_OVERRUN_EN.
module req_encoder_4to2 #(
    parameter int RR_EN    = 1,   // 1 = round-robin, 0 = fixed priority (lowest index wins)
    parameter int PTR_INIT = 0    // reset value of the round-robin pointer, 0..3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [1:0] idx,
    output logic [3:0] pending
`ifdef REQ_ENC_OVERRUN_EN
    ,
    output logic       overrun,
    input  logic       overrun_clr
`endif
);

    localparam logic [1:0] PTR_RST = PTR_INIT[1:0];

    logic [1:0] ptr;
    logic [1:0] base;
    logic [1:0] cand;
    logic [1:0] win;
    logic       found;
    logic       load;
    logic       has_pending;
    logic [3:0] clr;
    logic [3:0] pending_next;

    assign load        = !valid || ready;
    assign has_pending = |pending;

    // Fixed priority is the same scan as round-robin, just always starting at line 0.
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        base  = (RR_EN != 0) ? ptr : 2'd0;
        cand  = 2'd0;
        win   = base;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = base + 2'(k);
            if (!found && pending[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        clr = 4'b0000;
        if (load && has_pending) begin
            clr = 4'b0001 << win;
        end
        // Set wins over clear: a strobe arriving on the granted line re-arms it.
        pending_next = (pending & ~clr) | req;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 4'b0000;
            valid   <= 1'b0;
            idx     <= 2'b00;
            ptr     <= PTR_RST;
        end else begin
            pending <= pending_next;
            if (load) begin
                if (has_pending) begin
                    valid <= 1'b1;
                    idx   <= win;
                    if (RR_EN != 0) begin
                        ptr <= win + 2'd1;
                    end
                end else begin
                    valid <= 1'b0;
                end
            end
        end
    end

`ifdef REQ_ENC_OVERRUN_EN
    logic overrun_set;

    // A strobe on a line that is already pending and not being granted is a lost event.
    assign overrun_set = |(req & pending & ~clr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Directed bench for req_encoder_4to2: a round-robin instance and a fixed-priority instance
// share stimulus; expected values are hand-computed per step.
module tb_req_encoder_4to2;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       ready;
    logic       overrun_clr;

    logic       valid_rr, valid_fp;
    logic [1:0] idx_rr, idx_fp;
    logic [3:0] pend_rr, pend_fp;
    logic       ovr_rr, ovr_fp;

    int n_cmp  = 0;
    int n_fail = 0;

    req_encoder_4to2 #(.RR_EN(1), .PTR_INIT(0)) dut_rr (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ready       (ready),
        .valid       (valid_rr),
        .idx         (idx_rr),
        .pending     (pend_rr)
`ifdef REQ_ENC_OVERRUN_EN
        ,
        .overrun     (ovr_rr),
        .overrun_clr (overrun_clr)
`endif
    );

    req_encoder_4to2 #(.RR_EN(0), .PTR_INIT(0)) dut_fp (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ready       (ready),
        .valid       (valid_fp),
        .idx         (idx_fp),
        .pending     (pend_fp)
`ifdef REQ_ENC_OVERRUN_EN
        ,
        .overrun     (ovr_fp),
        .overrun_clr (overrun_clr)
`endif
    );

`ifndef REQ_ENC_OVERRUN_EN
    assign ovr_rr = 1'b0;
    assign ovr_fp = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it, away from the sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        req         = 4'b0000;
        ready       = 1'b1;
        overrun_clr = 1'b0;
        tick();
        tick();
        check("rst_valid", 8'(valid_rr), 8'd0);
        check("rst_idx",   8'(idx_rr),   8'd0);
        check("rst_pend",  8'(pend_rr),  8'h0);
        reset = 1'b0;

        // Single request on line 2.
        req = 4'b0100;
        tick();
        req = 4'b0000;
        check("single_pend_e1",  8'(pend_rr),  8'h4);
        check("single_valid_e1", 8'(valid_rr), 8'd0);
        tick();
        check("single_valid_e2", 8'(valid_rr), 8'd1);
        check("single_idx_e2",   8'(idx_rr),   8'd2);
        check("single_pend_e2",  8'(pend_rr),  8'h0);
        tick();
        check("single_valid_e3", 8'(valid_rr), 8'd0);
        check("single_pend_e3",  8'(pend_rr),  8'h0);

        // Pointer is now 3: lines 3 and 0 pending must go 3 then 0 (wrap 3 -> 0).
        req = 4'b1001;
        tick();
        req = 4'b0000;
        tick();
        check("wrap_idx_a", 8'(idx_rr), 8'd3);
        tick();
        check("wrap_idx_b", 8'(idx_rr), 8'd0);
        tick();
        check("wrap_valid_end", 8'(valid_rr), 8'd0);

        // Round-robin drain of all four lines from PTR_INIT=0.
        do_reset();
        req = 4'b1111;
        tick();
        req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_valid", 8'(valid_rr), 8'd1);
            check("rr_idx",   8'(idx_rr),   8'(k));
        end
        tick();
        check("rr_valid_end", 8'(valid_rr), 8'd0);

        // Backpressure: output must hold while ready is low.
        do_reset();
        ready = 1'b0;
        req   = 4'b0011;
        tick();
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", 8'(valid_rr), 8'd1);
            check("bp_idx",   8'(idx_rr),   8'd0);
            check("bp_pend",  8'(pend_rr),  8'h2);
        end
        ready = 1'b1;
        tick();
        check("bp_idx_next",  8'(idx_rr),   8'd1);
        check("bp_valid_nx",  8'(valid_rr), 8'd1);
        tick();
        check("bp_valid_end", 8'(valid_rr), 8'd0);

        // Continuous req on lines 0 and 3: fixed priority starves 3, round-robin alternates.
        do_reset();
        req = 4'b1001;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fp_valid", 8'(valid_fp), 8'd1);
            check("fp_idx",   8'(idx_fp),   8'd0);
            check("rr_alt",   8'(idx_rr),   (k % 2 == 0) ? 8'd0 : 8'd3);
        end
`ifdef REQ_ENC_OVERRUN_EN
        check("fp_overrun_set", 8'(ovr_fp), 8'd1);
        req         = 4'b0000;
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("fp_overrun_clr", 8'(ovr_fp), 8'd0);
`endif
        req = 4'b0000;

        // Set wins over clear: re-request line 0 on the cycle it is granted.
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("swc_idx_a",  8'(idx_rr),   8'd0);
        check("swc_pend_a", 8'(pend_rr),  8'h1);
        tick();
        check("swc_idx_b",   8'(idx_rr),   8'd0);
        check("swc_valid_b", 8'(valid_rr), 8'd1);
        check("swc_pend_b",  8'(pend_rr),  8'h0);
        check("swc_overrun", 8'(ovr_rr),   8'd0);
        tick();
        check("swc_valid_end", 8'(valid_rr), 8'd0);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        req = 4'b1110;
        tick();
        req = 4'b0000;
        tick();
        check("mid_first_idx", 8'(idx_rr), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 8'(valid_rr), 8'd0);
        check("mid_rst_pend",  8'(pend_rr),  8'h0);
        check("mid_rst_idx",   8'(idx_rr),   8'd0);
        tick();
        reset = 1'b0;
        req   = 4'b1000;
        tick();
        req = 4'b0000;
        check("post_rst_valid_e1", 8'(valid_rr), 8'd0);
        check("post_rst_pend_e1",  8'(pend_rr),  8'h8);
        tick();
        check("post_rst_valid_e2", 8'(valid_rr), 8'd1);
        check("post_rst_idx_e2",   8'(idx_rr),   8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
